// File: rtl/wave_ram_arbiter_if.sv
// wave_ram_arbiter_if: capture, display and RAM signals of the arbiter.
// slave = arbiter side, master = client/RAM side.
interface wave_ram_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_full;
  logic              overflow;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_grant;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  wr_req, wr_addr, wr_data,
    input  rd_req, rd_addr, ram_rdata,
    output wr_full, overflow,
    output rd_grant, rd_valid, rd_data,
    output ram_addr, ram_we, ram_wdata
  );

  modport master (
    output wr_req, wr_addr, wr_data,
    output rd_req, rd_addr, ram_rdata,
    input  wr_full, overflow,
    input  rd_grant, rd_valid, rd_data,
    input  ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/wave_ram_arbiter.sv
// wave_ram_arbiter: shares a 1-port sample RAM between capture
// writes (FIFO-buffered) and priority display reads.
// Ports: clk, reset (async, active-low), bus (wave_ram_arbiter_if.slave).
module wave_ram_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_STREAK = 8
) (
  input logic               clk,
  input logic               reset,
  wave_ram_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int EW = ADDR_W + DATA_W;
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     head_ptr;
  logic [PW-1:0]     tail_ptr;
  logic [PW:0]       count_q;
  logic [SW-1:0]     streak_q;
  logic [SW-1:0]     streak_d;
  logic              ovf_q;
  logic              rd_valid_q;
  logic              fifo_empty;
  logic              fifo_full;
  logic              forced;
  logic              grant;
  logic              pop;
  logic              push;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign {head_addr, head_data} = fifo_mem[head_ptr];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign forced = !fifo_empty &&
                  (streak_q == STREAK_MAX);

  // reset gates the combinational outputs so they
  // drop the moment reset is asserted
  assign grant = reset && bus.rd_req && !forced;
  assign pop   = reset && !fifo_empty &&
                 (forced || !bus.rd_req);
  assign push  = reset && bus.wr_req &&
                 (!fifo_full || pop);

  always_comb begin
    bus.ram_we    = pop;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    unique case (1'b1)
      pop: begin
        bus.ram_addr  = head_addr;
        bus.ram_wdata = head_data;
      end
      grant: bus.ram_addr = bus.rd_addr;
      default: ;
    endcase
  end

  always_comb begin
    streak_d = streak_q;
    if (fifo_empty || pop)
      streak_d = '0;
    else if (grant && streak_q != STREAK_MAX)
      streak_d = streak_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      count_q    <= '0;
      streak_q   <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      if (pop)
        head_ptr <= head_ptr + 1'b1;
      if (push)
        tail_ptr <= tail_ptr + 1'b1;
      count_q <= count_q
               + (PW + 1)'(push)
               - (PW + 1)'(pop);
      streak_q <= streak_d;
      if (bus.wr_req && fifo_full && !pop)
        ovf_q <= 1'b1;
      rd_valid_q <= grant;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[tail_ptr] <= {bus.wr_addr, bus.wr_data};
  end

  assign bus.wr_full  = fifo_full;
  assign bus.overflow = ovf_q;
  assign bus.rd_grant = grant;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_valid_q ? bus.ram_rdata
                                   : '0;
endmodule

// File: tb/tb_wave_ram_arbiter.sv
// tb_wave_ram_arbiter: randomized scoreboard bench with a
// queue-based reference model and a behavioural sync RAM.
module tb_wave_ram_arbiter;
  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int MAXS  = 8;

  typedef struct packed {
    logic          grant;
    logic          we;
    logic          valid;
    logic          full;
    logic          ovf;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cyc_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wave_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  wave_ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .FIFO_DEPTH(DEPTH), .MAX_STREAK(MAXS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [DW-1:0] ram [1 << AW];
  logic [DW-1:0] model_ram [1 << AW];

  cyc_t          exp_cyc [$];
  logic [DW-1:0] exp_rd  [$];
  wr_t           wq      [$];
  int            streak;
  bit            ovf;
  bit            prev_grant;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h",
               name, act, exp);
    end
  endtask

  // synchronous-read RAM, read-before-write
  initial begin
    for (int i = 0; i < (1 << AW); i++)
      ram[i] = 8'($urandom);
    ram[9'h1A0] = 8'h7E;
    forever begin
      @(posedge clk);
      bus.ram_rdata <= ram[bus.ram_addr];
      if (bus.ram_we === 1'b1)
        ram[bus.ram_addr] = bus.ram_wdata;
    end
  end

  // monitor: one expected record per running cycle,
  // read data popped whenever the DUT shows rd_valid
  initial begin
    cyc_t c;
    forever begin
      @(negedge clk);
      if (reset && exp_cyc.size() > 0) begin
        c = exp_cyc.pop_front();
        chk("rd_grant", bus.rd_grant, c.grant);
        chk("ram_we", bus.ram_we, c.we);
        chk("ram_addr", bus.ram_addr, c.addr);
        chk("ram_wdata", bus.ram_wdata, c.wdata);
        chk("rd_valid", bus.rd_valid, c.valid);
        chk("wr_full", bus.wr_full, c.full);
        chk("overflow", bus.overflow, c.ovf);
        if (bus.rd_valid === 1'b1) begin
          if (exp_rd.size() == 0)
            chk("rd_data_unexpected", 1, 0);
          else
            chk("rd_data", bus.rd_data,
                exp_rd.pop_front());
        end
      end
    end
  end

  function automatic logic [AW-1:0] raddr(bit hi);
    logic [3:0] lo;
    lo = 4'($urandom_range(0, 15));
    return {hi, 4'hA, lo};
  endfunction

  task automatic cycle(input bit rd,
                       input logic [AW-1:0] ra,
                       input bit wr,
                       input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd);
    cyc_t c;
    bit   empty;
    bit   do_w;
    @(posedge clk);
    #1;
    reset       = 1'b1;
    bus.rd_req  = rd;
    bus.rd_addr = ra;
    bus.wr_req  = wr;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    c       = '0;
    c.valid = prev_grant;
    c.full  = (wq.size() == DEPTH);
    c.ovf   = ovf;
    empty   = (wq.size() == 0);
    do_w    = !empty && (streak == MAXS || !rd);
    if (do_w) begin
      c.we    = 1'b1;
      c.addr  = wq[0].a;
      c.wdata = wq[0].d;
      model_ram[wq[0].a] = wq[0].d;
      void'(wq.pop_front());
    end else if (rd) begin
      c.grant = 1'b1;
      c.addr  = ra;
      exp_rd.push_back(model_ram[ra]);
    end
    if (wr) begin
      if (wq.size() < DEPTH)
        wq.push_back(wr_t'{a: wa, d: wd});
      else
        ovf = 1'b1;
    end
    if (empty || do_w)
      streak = 0;
    else if (c.grant && streak < MAXS)
      streak++;
    prev_grant = c.grant;
    exp_cyc.push_back(c);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ram_we"}, bus.ram_we, 0);
    chk({tag, "_ram_addr"}, bus.ram_addr, 0);
    chk({tag, "_ram_wdata"}, bus.ram_wdata, 0);
    chk({tag, "_rd_grant"}, bus.rd_grant, 0);
    chk({tag, "_rd_valid"}, bus.rd_valid, 0);
    chk({tag, "_wr_full"}, bus.wr_full, 0);
    chk({tag, "_overflow"}, bus.overflow, 0);
    chk({tag, "_rd_data"}, bus.rd_data, 0);
  endtask

  // reset asserted mid-cycle, inputs left as they were
  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk_zero("rst_async");
    wq.delete();
    exp_cyc.delete();
    exp_rd.delete();
    streak     = 0;
    ovf        = 1'b0;
    prev_grant = 1'b0;
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst_hold");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(0, '0, 0, '0, '0);
  endtask

  initial begin
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    streak      = 0;
    ovf         = 1'b0;
    prev_grant  = 1'b0;
    #1;
    for (int i = 0; i < (1 << AW); i++)
      model_ram[i] = ram[i];
    do_reset();

    cycle(1, 9'h1A0, 0, '0, '0);
    idle(2);

    cycle(1, raddr(1), 1, 9'h0A3, 8'($urandom));
    for (int i = 1; i < 20; i++)
      cycle(1, raddr(1), 0, '0, '0);
    idle(2);

    for (int i = 0; i < 5; i++)
      cycle(1, raddr(1), 1, 9'h0A0 + 9'(i),
            8'($urandom));
    cycle(0, '0, 1, 9'h0A5, 8'($urandom));
    idle(6);
    for (int i = 0; i < 6; i++)
      cycle(1, 9'h0A0 + 9'(i), 0, '0, '0);
    idle(2);

    do_reset();
    for (int i = 0; i < 3; i++)
      cycle(1, raddr(1), 1, 9'h0A8 + 9'(i),
            8'($urandom));
    idle(5);

    cycle(1, raddr(1), 1, raddr(0), 8'($urandom));
    cycle(1, raddr(1), 1, raddr(0), 8'($urandom));
    do_reset();
    cycle(0, '0, 1, 9'h005, 8'h4B);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      if (i == 200)
        do_reset();
      cycle($urandom_range(0, 9) < 7,
            raddr(1'($urandom)),
            $urandom_range(0, 9) < 4,
            raddr(1'($urandom)),
            8'($urandom));
    end
    idle(8);
    @(posedge clk);
    #1;
    chk("leftover_reads", exp_rd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
